// File: rtl/rns_mod31_reverse_conv.sv
// Residue-to-binary converter for the {31, 32, 33} moduli set (M = 32736).
// Mixed-radix conversion sequenced over four compute states with valid/ready on both sides.
module rns_mod31_reverse_conv #(
  parameter bit SIGNED_OUT  = 1'b0,
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  r31,
  input  logic [4:0]  r32,
  input  logic [5:0]  r33,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_err
);

  typedef enum logic [2:0] {
    StIdle,
    StY,
    StD,
    StZ,
    StX,
    StOut
  } state_e;

  state_e state_q, state_d;

  logic [4:0]  r31_q, r32_q;
  logic [5:0]  r33_q;
  logic [4:0]  y1_q;
  logic [5:0]  d_q;
  logic [5:0]  z_q;
  logic [15:0] out_data_q;
  logic        out_err_q;

  // Combinational per-stage results
  logic [4:0]  a_val;
  logic [5:0]  y_sum;
  logic [4:0]  y1_d;
  logic [5:0]  r33_m;
  logic [6:0]  d_sum, d_red1, d_red2;
  logic [5:0]  d_d;
  logic [9:0]  prod17;
  logic [6:0]  z_sum;
  logic [5:0]  z_d;
  logic [14:0] x_val;
  logic [15:0] x_out;
  logic        bad_r33;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StY;
      StY:     state_d = StD;
      StD:     state_d = StZ;
      StZ:     state_d = StX;
      StX:     state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // y1 = (r31 - r32) mod 31; 31 is the redundant zero encoding
  always_comb begin
    a_val = (r31_q == 5'd31) ? 5'd0 : r31_q;
    y_sum = {1'b0, a_val} + 6'd31 - {1'b0, r32_q};
    y1_d  = (y_sum >= 6'd31) ? 5'(y_sum - 6'd31) : y_sum[4:0];
  end

  // d = (r33 + y1 - r32) mod 33, biased by 33 so the sum never goes negative
  always_comb begin
    r33_m  = (r33_q >= 6'd33) ? (r33_q - 6'd33) : r33_q;
    d_sum  = {1'b0, r33_m} + {2'b0, y1_q} + 7'd33 - {2'b0, r32_q};
    d_red1 = (d_sum >= 7'd33) ? (d_sum - 7'd33) : d_sum;
    d_red2 = (d_red1 >= 7'd33) ? (d_red1 - 7'd33) : d_red1;
    d_d    = 6'(d_red2);
  end

  // z = 17*d mod 33; fold the product using 32 == -1 (mod 33)
  always_comb begin
    prod17 = {d_q, 4'b0000} + {4'b0000, d_q};
    z_sum  = {2'b00, prod17[4:0]} + 7'd33 - {2'b00, prod17[9:5]};
    z_d    = (z_sum >= 7'd33) ? 6'(z_sum - 7'd33) : 6'(z_sum);
  end

  always_comb begin
    x_val   = 15'(r32_q) + (15'(y1_q) << 5) + 15'(z_q) * 15'd992;
    bad_r33 = RANGE_CHECK && (r33_q > 6'd32);
    if (SIGNED_OUT && (x_val >= 15'd16368)) begin
      // X - 32736 modulo 2^16
      x_out = {1'b0, x_val} + 16'd32800;
    end else begin
      x_out = {1'b0, x_val};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r31_q      <= '0;
      r32_q      <= '0;
      r33_q      <= '0;
      y1_q       <= '0;
      d_q        <= '0;
      z_q        <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            r31_q <= r31;
            r32_q <= r32;
            r33_q <= r33;
          end
        end
        StY: y1_q <= y1_d;
        StD: d_q  <= d_d;
        StZ: z_q  <= z_d;
        StX: begin
          out_data_q <= bad_r33 ? 16'd0 : x_out;
          out_err_q  <= bad_r33;
        end
        StOut: begin
          if (out_ready) out_err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_rns_mod31_reverse_conv.sv
// Scoreboard bench: two converter builds (unsigned/range-checked and signed/unchecked) share stimulus.
module tb_rns_mod31_reverse_conv;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [4:0]  r31, r32;
  logic [5:0]  r33;
  logic        in_ready, out_valid, out_err;
  logic [15:0] out_data;
  logic        in_ready_s, out_valid_s, out_err_s;
  logic [15:0] out_data_s;

  typedef struct {
    logic [15:0] du;
    logic        eu;
    logic [15:0] ds;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   seen = 0;
  bit   rel_pend = 0;

  rns_mod31_reverse_conv #(
    .SIGNED_OUT  (1'b0),
    .RANGE_CHECK (1'b1)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r31       (r31),
    .r32       (r32),
    .r33       (r33),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  rns_mod31_reverse_conv #(
    .SIGNED_OUT  (1'b1),
    .RANGE_CHECK (1'b0)
  ) u_dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .r31       (r31),
    .r32       (r32),
    .r33       (r33),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_data  (out_data_s),
    .out_err   (out_err_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Brute-force CRT search, independent of the mixed-radix structure
  function automatic int crt(input int a, input int b, input int c);
    for (int x = 0; x < 32736; x++) begin
      if ((x % 31 == a) && (x % 32 == b) && (x % 33 == c)) return x;
    end
    return -1;
  endfunction

  function automatic logic [15:0] to_signed(input int x);
    return (x >= 16368) ? 16'(x - 32736) : 16'(x);
  endfunction

  task automatic send(input logic [4:0] a, input logic [4:0] b, input logic [5:0] c,
                      input int hold);
    exp_t e;
    int   x;
    bit   done;
    done = 0;
    x    = crt(int'(a) % 31, int'(b), int'(c) % 33);
    e.eu = (c > 6'd32);
    e.du = e.eu ? 16'd0 : 16'(x);
    e.ds = to_signed(x);
    e.acc = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        r31 = a;
        r32 = b;
        r33 = c;
        in_valid = 1'b1;
        e.acc = cyc + 1;
        q.push_back(e);
        done = 1;
      end
    end
    if (!done) begin
      check_eq("accept_timeout", 0, 1);
      return;
    end
    @(posedge clk);
    #1;
    // Junk on the inputs after acceptance must not disturb the conversion
    r31 = 5'($urandom);
    r32 = 5'($urandom);
    r33 = 6'($urandom);
    in_valid = (hold > 0);
    repeat (hold) @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_x(input int x, input int hold);
    send(5'(x % 31), 5'(x % 32), 6'(x % 33), hold);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check_eq("drain_timeout", q.size(), 0);
      q.delete();
      seen = 0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_sb();
    q.delete();
    seen = 0;
    rel_pend = 0;
  endtask

  // Output monitor
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rel_pend) begin
        check_eq("rel_in_ready", in_ready, 1);
        check_eq("rel_out_valid", out_valid, 0);
        rel_pend = 0;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check_eq("unexpected_out", 1, 0);
        end else begin
          if (!seen) begin
            seen = 1;
            check_eq("latency", cyc - q[0].acc, 4);
            check_eq("err_u", out_err, q[0].eu);
            check_eq("valid_s", out_valid_s, 1);
            check_eq("data_s", out_data_s, q[0].ds);
            check_eq("err_s", out_err_s, 0);
          end
          check_eq("data_u", out_data, q[0].du);
          check_eq("hold_in_ready", in_ready | in_ready_s, 0);
          if (out_ready) begin
            void'(q.pop_front());
            seen = 0;
            rel_pend = 1;
          end
        end
      end
    end
  end

  initial begin
    int x;
    logic [4:0] a;
    logic [5:0] c;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    r31 = '0;
    r32 = '0;
    r33 = '0;
    #12;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_err", out_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    send(5'd8, 5'd8, 6'd10, 3);
    send(5'd30, 5'd31, 6'd32, 3);
    send(5'd31, 5'd0, 6'd0, 3);
    send(5'd0, 5'd0, 6'd0, 1);
    send_x(16367, 2);
    send_x(16368, 0);
    send_x(31, 3);
    send_x(32, 1);
    send_x(33, 3);
    send(5'd8, 5'd8, 6'd40, 3);
    send(5'd8, 5'd8, 6'd10, 3);
    drain();

    for (int i = 0; i < 20; i++) begin
      x = int'($urandom_range(0, 32735));
      a = 5'(x % 31);
      c = 6'(x % 33);
      if (a == 5'd0 && $urandom_range(0, 1) == 1) a = 5'd31;
      if (c <= 6'd30 && $urandom_range(0, 3) == 0) c = c + 6'd33;
      send(a, 5'(x % 32), c, int'($urandom_range(0, 3)));
    end
    drain();

    // Backpressure
    out_ready = 1'b0;
    send_x(12345, 3);
    repeat (12) @(posedge clk);
    #1;
    check_eq("bp_still_valid", out_valid, 1);
    out_ready = 1'b1;
    drain();

    // Reset while in the z stage
    send(5'd31, 5'd0, 6'd0, 2);
    rst = 1'b1;
    #1;
    check_eq("rstz_in_ready", in_ready, 1);
    check_eq("rstz_out_valid", out_valid, 0);
    clear_sb();
    @(posedge clk);
    #1 rst = 1'b0;
    send(5'd31, 5'd0, 6'd0, 3);
    drain();

    // Reset while a result is waiting
    out_ready = 1'b0;
    send_x(777, 3);
    @(posedge clk);
    #1;
    check_eq("rsto_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check_eq("rsto_out_valid", out_valid, 0);
    check_eq("rsto_out_data", out_data, 0);
    check_eq("rsto_in_ready", in_ready, 1);
    clear_sb();
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send_x(4321, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
